// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register for back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 584,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_d
);

  localparam int unsigned BaudW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BitLast  = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BaudW-1:0] StopLast = BaudW'(STOP_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             tx_d_q, tx_d_d;
  logic             load;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d_d      = tx_d_q;
    load        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (hold_full_q) load = 1'b1;
      end
      StStart: begin
        if (baud_q == BitLast) begin
          state_d = StData;
          baud_d  = '0;
          bit_d   = '0;
          tx_d_d  = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_q == BitLast) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d_d  = parity_q;
`else
            state_d = StStop;
            tx_d_d  = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_q == BitLast) begin
          state_d = StStop;
          baud_d  = '0;
          tx_d_d  = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (baud_q == StopLast) begin
          baud_d = '0;
          // Registered hold_full decides: a byte accepted on this very edge waits one cycle.
          if (hold_full_q) load = 1'b1;
          else             state_d = StIdle;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Accept and load are exclusive: accept needs an empty holder, load a full one.
    if (load) begin
      state_d     = StStart;
      tx_d_d      = 1'b0;
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      baud_d      = '0;
`ifdef UART_TX_PARITY_EN
      parity_d    = ^hold_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_d_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_d_q      <= tx_d_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign tx_ready = !hold_full_q;
  assign busy     = (state_q != StIdle) || hold_full_q;
  assign tx_d     = tx_d_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: two instances (1 and 2 stop bits), random and directed traffic.
module tb_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data  [2];
  logic       valid [2];
  logic       ready [2];
  logic       busy  [2];
  logic       txd   [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int         start0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(rst_n), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .busy(busy[0]), .tx_d(txd[0])
  );

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(rst_n), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .busy(busy[1]), .tx_d(txd[1])
  );

  function automatic int stop_bits(input int idx);
    return (idx == 0) ? 1 : 2;
  endfunction

  function automatic int frame_bits(input int idx);
    return 1 + 8 + Par + stop_bits(idx);
  endfunction

  function automatic int exp_size(input int idx);
    return (idx == 0) ? exp0.size() : exp1.size();
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Expected bytes are queued at the accept edge; the monitor pops them when a frame starts.
  task automatic send(input int idx, input logic [7:0] d, input bit scramble);
    int n = 0;
    @(negedge clk);
    valid[idx] = 1'b1;
    data[idx]  = d;
    while (!ready[idx] && n < 5000) begin
      @(negedge clk);
      if (scramble) data[idx] = 8'($urandom);
      n++;
    end
    if (n >= 5000) begin
      chk("accept_timeout", 32'(n), 32'(0));
    end else if (idx == 0) begin
      exp0.push_back(data[idx]);
    end else begin
      exp1.push_back(data[idx]);
    end
    @(posedge clk);
    #1;
    valid[idx] = 1'b0;
  endtask

  task automatic wait_idle(input int idx);
    int n = 0;
    while ((busy[idx] || exp_size(idx) != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(n < 5000), 32'(1));
    repeat (2) @(negedge clk);
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop bits high.
  task automatic monitor(input int idx);
    logic       bits [12];
    logic [7:0] b;
    int         nb;
    bit         aborted;
    bit         bad;
    logic       gotv;
    forever begin
      @(negedge clk);
      if (rst_n && txd[idx] === 1'b0) begin
        if (exp_size(idx) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: dut%0d started a frame with nothing queued", idx);
          while (rst_n && txd[idx] !== 1'b1) @(negedge clk);
        end else begin
          b  = (idx == 0) ? exp0.pop_front() : exp1.pop_front();
          if (idx == 0) start0.push_back(cyc);
          nb = 0;
          bits[nb++] = 1'b0;
          for (int i = 0; i < 8; i++) bits[nb++] = b[i];
          if (Par == 1) bits[nb++] = ^b;
          for (int i = 0; i < stop_bits(idx); i++) bits[nb++] = 1'b1;
          aborted = 1'b0;
          for (int i = 0; i < nb; i++) begin
            bad  = 1'b0;
            gotv = bits[i];
            for (int c = 0; c < C; c++) begin
              if (i > 0 || c > 0) @(negedge clk);
              if (!rst_n) begin
                aborted = 1'b1;
                break;
              end
              if (txd[idx] !== bits[i]) begin
                bad  = 1'b1;
                gotv = txd[idx];
              end
            end
            if (aborted) break;
            checks++;
            if (bad) begin
              errors++;
              $display("FAIL frame_bit: dut%0d byte %02h bit %0d got=%b expected=%b",
                       idx, b, i, gotv, bits[i]);
            end
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int  t;
    int  n;
    int  s0;
    bit  ok;
    rst_n    = 1'b0;
    valid[0] = 1'b0;
    valid[1] = 1'b0;
    data[0]  = 8'h00;
    data[1]  = 8'h00;

    // Reset state and quiet line after release
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_tx_d", 32'(txd[i]), 32'(1));
      chk("reset_ready", 32'(ready[i]), 32'(1));
      chk("reset_busy", 32'(busy[i]), 32'(0));
    end
    #2 rst_n = 1'b1;
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || txd[1] !== 1'b1) ok = 1'b0;
    end
    chk("idle_line_high", 32'(ok), 32'(1));

    // Single 0xA5 frame: start latency and busy duration
    send(0, 8'hA5, 1'b0);
    t = 0;
    while (txd[0] !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("start_latency", 32'(t), 32'(2));
    n = 0;
    while (busy[0] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_length", 32'(n), 32'(frame_bits(0) * C));
    wait_idle(0);

    // Back-to-back bytes: no idle gap, third offer stalls
    start0.delete();
    send(0, 8'h00, 1'b0);
    send(0, 8'hFF, 1'b0);
    @(negedge clk);
    chk("stall_ready", 32'(ready[0]), 32'(0));
    send(0, 8'h5A, 1'b0);
    wait_idle(0);
    chk("b2b_frames", 32'(start0.size()), 32'(3));
    if (start0.size() == 3) begin
      chk("b2b_gap_1", 32'(start0[1] - start0[0]), 32'(frame_bits(0) * C));
      chk("b2b_gap_2", 32'(start0[2] - start0[1]), 32'(frame_bits(0) * C));
    end

    // Parity corner bytes and random traffic with random gaps
    send(0, 8'h07, 1'b0);
    send(0, 8'h03, 1'b0);
    for (int i = 0; i < 24; i++) begin
      send(0, 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(0);

    // Reset mid-frame during data bit 4 of 0x3C with 0x99 held
    start0.delete();
    send(0, 8'h3C, 1'b0);
    send(0, 8'h99, 1'b0);
    n = 0;
    while (start0.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_frame_started", 32'(start0.size() != 0), 32'(1));
    s0 = (start0.size() != 0) ? start0[0] : cyc;
    while (cyc < s0 + 5 * C + 1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_tx_d", 32'(txd[0]), 32'(1));
    chk("async_reset_ready", 32'(ready[0]), 32'(1));
    chk("async_reset_busy", 32'(busy[0]), 32'(0));
    @(negedge clk);
    @(negedge clk);
    exp0.delete();
    start0.delete();
    #2 rst_n = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) ok = 1'b0;
    end
    chk("held_byte_lost", 32'(ok), 32'(1));
    send(0, 8'h55, 1'b0);
    wait_idle(0);

    // Two stop bits; stalled offers with changing data
    send(1, 8'h81, 1'b0);
    send(1, 8'($urandom), 1'b1);
    send(1, 8'($urandom), 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(1, 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
